// File: rtl/an_code_pkg.sv
// Shared AN-code constants and encoder state encoding, common to the encoder and decoder.
package an_code_pkg;

    localparam int A        = 1939;
    localparam int A_BITS   = 11;
    localparam int D_BITS   = 8;
    localparam int W_BITS   = 20;
    localparam int POS_BITS = $clog2(W_BITS);
    localparam int CNT_BITS = $clog2(D_BITS);

    localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);
    localparam logic [W_BITS-1:0] A_W   = {{(W_BITS-A_BITS){1'b0}}, A_VEC};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        INJ  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/an_err_inject.sv
// Combinational arithmetic error injector: adds or subtracts 2^err_pos from the codeword.
import an_code_pkg::*;

module an_err_inject (
    input  logic [W_BITS-1:0]   acc,
    input  logic                err_en,
    input  logic                err_sign,
    input  logic [POS_BITS-1:0] err_pos,
    output logic [W_BITS-1:0]   w
);

    logic [W_BITS-1:0] delta;

    // Positions past W_BITS-2 would leave no headroom, so they suppress the injection.
    always_comb begin
        delta = W_BITS'(1) << err_pos;
        w     = acc;
        if (err_en && (err_pos <= POS_BITS'(W_BITS - 2))) begin
            w = err_sign ? (acc - delta) : (acc + delta);
        end
    end

endmodule

// File: rtl/an_encoder_8bits.sv
// AN-code arithmetic encoder W = A*D: shift-add multiplier, one partial product per cycle.
// Define ERR_INJECT_EN to add err_en/err_sign/err_pos ports for single-error injection.
import an_code_pkg::*;

module an_encoder_8bits (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [D_BITS-1:0] D,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic              busy
`ifdef ERR_INJECT_EN
    ,
    input  logic                err_en,
    input  logic                err_sign,
    input  logic [POS_BITS-1:0] err_pos
`endif
);

    state_t state, state_next;

    logic [W_BITS-1:0]   acc;
    logic [D_BITS-1:0]   mcand;
    logic [CNT_BITS-1:0] count;
    logic [W_BITS-1:0]   w_next;

    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(D_BITS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)            state_next = MUL;
            MUL:  if (count == LAST_COUNT) state_next = INJ;
            INJ:                           state_next = HOLD;
            HOLD: if (out_ready)           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Handshake flags decode straight from state so a reset drops them without waiting for a clock.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

`ifdef ERR_INJECT_EN
    logic                err_en_q;
    logic                err_sign_q;
    logic [POS_BITS-1:0] err_pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_en_q   <= 1'b0;
            err_sign_q <= 1'b0;
            err_pos_q  <= '0;
        end else if (state == IDLE && in_valid) begin
            err_en_q   <= err_en;
            err_sign_q <= err_sign;
            err_pos_q  <= err_pos;
        end
    end

    an_err_inject u_err_inject (
        .acc      (acc),
        .err_en   (err_en_q),
        .err_sign (err_sign_q),
        .err_pos  (err_pos_q),
        .w        (w_next)
    );
`else
    assign w_next = acc;
`endif

    // Always runs all D_BITS steps, so latency never depends on the data value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            count <= '0;
            W     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= D;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                MUL: begin
                    if (mcand[0]) begin
                        acc <= acc + (A_W << count);
                    end
                    mcand <= mcand >> 1;
                    count <= count + 1'b1;
                end
                INJ: begin
                    W <= w_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_an_encoder_8bits.sv
// Self-checking bench for an_encoder_8bits against an arithmetic reference model.
// Define ERR_INJECT_EN when compiling to also exercise the error-injection ports.
import an_code_pkg::*;

module tb_an_encoder_8bits;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [D_BITS-1:0] D;
    logic              out_valid;
    logic              out_ready;
    logic [W_BITS-1:0] W;
    logic              busy;
`ifdef ERR_INJECT_EN
    logic                err_en;
    logic                err_sign;
    logic [POS_BITS-1:0] err_pos;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    an_encoder_8bits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .W         (W),
        .busy      (busy)
`ifdef ERR_INJECT_EN
        ,
        .err_en    (err_en),
        .err_sign  (err_sign),
        .err_pos   (err_pos)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer product, optional +/-2^pos, reduced modulo 2^W_BITS.
    function automatic logic [W_BITS-1:0] model_w(input int unsigned d, input bit en,
                                                  input bit sign, input int unsigned pos);
        longint v;
        v = longint'(A) * longint'(d);
        if (en && pos <= W_BITS - 2) begin
            if (sign) v = v - (longint'(1) << pos);
            else      v = v + (longint'(1) << pos);
        end
        return W_BITS'(v);
    endfunction

    // Drives one word through; ready_delay < 0 holds out_ready high from before the accept.
    task automatic run_word(input logic [D_BITS-1:0] d, input int ready_delay,
                            output logic [W_BITS-1:0] w, output int lat);
        int g;
        g = 0;
        D = d;
        in_valid = 1'b1;
        if (ready_delay < 0) out_ready = 1'b1;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        w = out_valid ? W : 'x;
        for (int i = 0; i < ready_delay; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (W !== '0) begin n_fail++; $display("[TB] FAIL reset_W got %0d want 0", W); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [D_BITS-1:0] vec [4] = '{8'd0, 8'd1, 8'd255, 8'd5};
        logic [W_BITS-1:0] want [4] = '{20'd0, 20'd1939, 20'd494445, 20'd9695};
        logic [W_BITS-1:0] w;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_word(vec[i], 0, w, lat);
            n_checks++;
            if (w !== want[i] || w !== model_w(vec[i], 0, 0, 0)) begin
                n_fail++;
                $display("[TB] FAIL directed_W D=%0d got %0d want %0d", vec[i], w, want[i]);
            end
            n_checks++;
            if (lat !== D_BITS + 1) begin
                n_fail++;
                $display("[TB] FAIL directed_latency D=%0d got %0d want %0d", vec[i], lat, D_BITS + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [D_BITS-1:0] d;
        logic [W_BITS-1:0] w;
        int lat;
        int dly;
        for (int i = 0; i < 24; i++) begin
            d   = D_BITS'($urandom);
            dly = int'($urandom_range(0, 4)) - 1;
            run_word(d, dly, w, lat);
            n_checks++;
            if (w !== model_w(d, 0, 0, 0) || lat !== D_BITS + 1) begin
                n_fail++;
                $display("[TB] FAIL random_W D=%0d got %0d (lat %0d) want %0d (lat %0d)",
                         d, w, lat, model_w(d, 0, 0, 0), D_BITS + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [D_BITS-1:0] d;
        logic [W_BITS-1:0] want;
        int g;
        d = D_BITS'($urandom_range(1, 255));
        want = model_w(d, 0, 0, 0);
        D = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || W !== want || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL backpressure_hold cyc=%0d got v=%b W=%0d rdy=%b busy=%b want v=1 W=%0d rdy=0 busy=1",
                         i, out_valid, W, in_ready, busy, want);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL backpressure_release got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int g;
        bit leaked;
        D = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        D = 8'd7;
        g = 0;
        leaked = 1'b0;
        while (!out_valid && g < 50) begin
            if (in_ready) leaked = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        n_checks++;
        if (leaked || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_in_ready got ready-during-busy=%b want 0", leaked | in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || W !== model_w(3, 0, 0, 0)) begin
            n_fail++;
            $display("[TB] FAIL b2b_first got %0d want %0d", W, model_w(3, 0, 0, 0));
        end
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || W !== model_w(7, 0, 0, 0) || g !== D_BITS + 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_second got %0d (lat %0d) want %0d (lat %0d)",
                     W, g, model_w(7, 0, 0, 0), D_BITS + 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W_BITS-1:0] w;
        int lat;
        int g;
        D = 8'd255;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mul got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                     out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_word(8'd2, 0, w, lat);
        n_checks++;
        if (w !== 20'd3878 || lat !== D_BITS + 1) begin
            n_fail++;
            $display("[TB] FAIL reset_mul_next got %0d (lat %0d) want 3878 (lat %0d)", w, lat, D_BITS + 1);
        end
        D = 8'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || W !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_hold got v=%b W=%0d rdy=%b want v=0 W=0 rdy=1", out_valid, W, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef ERR_INJECT_EN
    task automatic test_err_inject();
        logic [D_BITS-1:0] d;
        logic [W_BITS-1:0] w;
        logic [W_BITS-1:0] want;
        int lat;
        int unsigned dv [4] = '{5, 3, 0, 255};
        bit          sv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int unsigned pv [4] = '{0, 4, 0, 18};
        logic [W_BITS-1:0] ev [4] = '{20'd9696, 20'd5801, 20'd1048575, 20'd756589};
        for (int i = 0; i < 4; i++) begin
            err_en = 1'b1; err_sign = sv[i]; err_pos = POS_BITS'(pv[i]);
            run_word(D_BITS'(dv[i]), 0, w, lat);
            n_checks++;
            if (w !== ev[i]) begin
                n_fail++;
                $display("[TB] FAIL err_vec D=%0d got %0d want %0d", dv[i], w, ev[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            d = D_BITS'($urandom);
            err_en = 1'($urandom); err_sign = 1'($urandom); err_pos = POS_BITS'($urandom);
            want = model_w(d, err_en, err_sign, err_pos);
            run_word(d, 0, w, lat);
            n_checks++;
            if (w !== want || lat !== D_BITS + 1) begin
                n_fail++;
                $display("[TB] FAIL err_random D=%0d pos=%0d got %0d want %0d", d, err_pos, w, want);
            end
        end
        err_en = 1'b0;
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        D         = '0;
`ifdef ERR_INJECT_EN
        err_en = 1'b0; err_sign = 1'b0; err_pos = '0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef ERR_INJECT_EN
        test_err_inject();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
